// File: rtl/mips_run_ctrl.sv
// Execution controller for the non-pipelined MIPS core: gates the core enable for continuous or N-cycle step runs.
// Latency: start/step take effect at the sampling edge; halt/abort drop the enable after the sampling edge.
// No backpressure: start/step/abort are level-sampled requests, honoured only in the states that accept them.
module mips_run_ctrl #(
  parameter int CNT_W  = 32,
  parameter int STEP_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic              i_step,
  input  logic [STEP_W-1:0] i_step_count,
  input  logic              i_halt,
  input  logic              i_abort,
  output logic              o_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic [2:0]        o_state,
  output logic [CNT_W-1:0]  o_cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_WAIT = 3'd2,
    S_STEP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic [STEP_W-1:0] rem_load;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  // A zero step length still executes one cycle.
  assign rem_load = (i_step_count == '0) ? STEP_W'(1) : i_step_count;

  // Next-state and counter update; abort outranks halt, which outranks step exhaustion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          cnt_d   = '0;
          state_d = i_mode ? S_WAIT : S_RUN;
        end
      end
      S_RUN: begin
        // The cycle that carries halt/abort was enabled, so it is counted.
        cnt_d = cnt_inc;
        if (i_abort || i_halt) begin
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        if (i_abort) begin
          state_d = S_DONE;
        end else if (i_step) begin
          state_d = S_STEP;
          rem_d   = rem_load;
        end
      end
      S_STEP: begin
        cnt_d = cnt_inc;
        rem_d = rem_q - STEP_W'(1);
        if (i_abort || i_halt) begin
          state_d = S_DONE;
        end else if (rem_q <= STEP_W'(1)) begin
          // Treating 0 like 1 keeps a corrupted remaining count from running away.
          state_d = S_WAIT;
        end
      end
      default: begin
        // Encodings 5..7 are unreachable; recover to IDLE.
        state_d = S_IDLE;
      end
    endcase
  end

  // State and counter registers; async reset drops the core enable immediately.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
    end
  end

  assign o_valid     = (state_q == S_RUN) || (state_q == S_STEP);
  assign o_busy      = (state_q == S_RUN) || (state_q == S_WAIT) || (state_q == S_STEP);
  assign o_done      = (state_q == S_DONE);
  assign o_state     = state_q;
  assign o_cycle_cnt = cnt_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: two instances (32-bit and 4-bit counters) share the same stimulus.
// Stimulus pushes the hand-computed state/count expected after each edge; a negedge monitor pops and compares.
module tb_mips_run_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start, mode, step, halt, abort;
  logic [7:0] step_count;

  logic        v32, b32, d32;
  logic [2:0]  s32;
  logic [31:0] c32;
  logic        v4, b4, d4;
  logic [2:0]  s4;
  logic [3:0]  c4;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]  st;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  mips_run_ctrl #(.CNT_W(32), .STEP_W(8)) dut32 (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_mode(mode), .i_step(step),
    .i_step_count(step_count), .i_halt(halt), .i_abort(abort),
    .o_valid(v32), .o_busy(b32), .o_done(d32), .o_state(s32), .o_cycle_cnt(c32)
  );

  mips_run_ctrl #(.CNT_W(4), .STEP_W(8)) dut4 (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_mode(mode), .i_step(step),
    .i_step_count(step_count), .i_halt(halt), .i_abort(abort),
    .o_valid(v4), .o_busy(b4), .o_done(d4), .o_state(s4), .o_cycle_cnt(c4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: one expectation per clock edge, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [3:0] e4;
      e  = exp_q.pop_front();
      e4 = (e.cnt > 32'd15) ? 4'd15 : e.cnt[3:0];
      chk("state32", {29'd0, s32}, {29'd0, e.st});
      chk("cnt32",   c32, e.cnt);
      chk("valid32", {31'd0, v32}, {31'd0, (e.st == 3'd1) || (e.st == 3'd3)});
      chk("busy32",  {31'd0, b32}, {31'd0, (e.st == 3'd1) || (e.st == 3'd2) || (e.st == 3'd3)});
      chk("done32",  {31'd0, d32}, {31'd0, (e.st == 3'd4)});
      chk("state4",  {29'd0, s4}, {29'd0, e.st});
      chk("cnt4",    {28'd0, c4}, {28'd0, e4});
      chk("valid4",  {31'd0, v4}, {31'd0, (e.st == 3'd1) || (e.st == 3'd3)});
    end
  end

  // Drive one cycle of inputs, then record what both DUTs must show after the edge.
  task automatic cyc(input logic st, input logic md, input logic sp, input logic [7:0] sc,
                     input logic h, input logic ab, input logic [2:0] es, input logic [31:0] ec);
    start      = st;
    mode       = md;
    step       = sp;
    step_count = sc;
    halt       = h;
    abort      = ab;
    @(posedge clk);
    exp_q.push_back(exp_t'{st: es, cnt: ec});
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 0; mode = 0; step = 0; step_count = 0; halt = 0; abort = 0;

    // Reset state
    cyc(0, 0, 0, 8'd0, 0, 0, 3'd0, 32'd0);
    cyc(0, 0, 0, 8'd0, 0, 0, 3'd0, 32'd0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 8'd0, 0, 0, 3'd0, 32'd0);

    // Continuous run, halt in the 10th enabled cycle
    cyc(1, 0, 0, 8'd0, 0, 0, 3'd1, 32'd0);
    for (int i = 1; i <= 9; i++) cyc(0, 0, 0, 8'd0, 0, 0, 3'd1, i);
    cyc(0, 0, 0, 8'd0, 1, 0, 3'd4, 32'd10);
    cyc(0, 0, 0, 8'd0, 0, 0, 3'd4, 32'd10);

    // Step mode, two 3-cycle bursts back to back
    cyc(1, 1, 0, 8'd0, 0, 0, 3'd2, 32'd0);
    cyc(0, 0, 1, 8'd3, 0, 0, 3'd3, 32'd0);
    cyc(0, 0, 0, 8'd0, 0, 0, 3'd3, 32'd1);
    cyc(0, 0, 0, 8'd0, 0, 0, 3'd3, 32'd2);
    cyc(0, 0, 0, 8'd0, 0, 0, 3'd2, 32'd3);
    cyc(0, 0, 1, 8'd3, 0, 0, 3'd3, 32'd3);
    cyc(0, 0, 0, 8'd0, 0, 0, 3'd3, 32'd4);
    cyc(0, 0, 0, 8'd0, 0, 0, 3'd3, 32'd5);
    cyc(0, 0, 0, 8'd0, 0, 0, 3'd2, 32'd6);
    cyc(0, 0, 0, 8'd0, 0, 0, 3'd2, 32'd6);

    // Abort from WAIT, restart in step mode, step length 0 runs one cycle
    cyc(0, 0, 0, 8'd0, 0, 1, 3'd4, 32'd6);
    cyc(1, 1, 0, 8'd0, 0, 0, 3'd2, 32'd0);
    cyc(0, 0, 1, 8'd0, 0, 0, 3'd3, 32'd0);
    cyc(0, 0, 0, 8'd0, 0, 0, 3'd2, 32'd1);

    // Halt and abort together with remaining=5; restart clears the count
    cyc(0, 0, 1, 8'd5, 0, 0, 3'd3, 32'd1);
    cyc(0, 0, 0, 8'd0, 1, 1, 3'd4, 32'd2);
    cyc(0, 0, 0, 8'd0, 0, 0, 3'd4, 32'd2);
    cyc(1, 0, 0, 8'd0, 0, 0, 3'd1, 32'd0);

    // 20 run cycles with start/step held (ignored), then abort; 4-bit count saturates at 15
    for (int i = 1; i <= 20; i++) cyc(1, 1, 1, 8'd2, 0, 0, 3'd1, i);
    cyc(0, 0, 0, 8'd0, 0, 1, 3'd4, 32'd21);
    cyc(0, 0, 0, 8'd0, 0, 0, 3'd4, 32'd21);

    // Asynchronous reset mid-run: outputs clear before the next edge
    cyc(1, 0, 0, 8'd0, 0, 0, 3'd1, 32'd0);
    cyc(0, 0, 0, 8'd0, 0, 0, 3'd1, 32'd1);
    cyc(0, 0, 0, 8'd0, 0, 0, 3'd1, 32'd2);
    start = 0; mode = 0; step = 0; halt = 0; abort = 0;
    @(posedge clk);
    exp_q.push_back(exp_t'{st: 3'd0, cnt: 32'd0});
    #1;
    rst_n = 1'b0;
    cyc(0, 0, 0, 8'd0, 0, 0, 3'd0, 32'd0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 8'd0, 0, 0, 3'd0, 32'd0);
    cyc(1, 1, 0, 8'd0, 0, 0, 3'd2, 32'd0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mips_run_ctrl.md
# mips_run_ctrl

Execution controller between the debug/host side and the non-pipelined MIPS core. It generates the core's `i_valid` enable and is parametrised in counter widths. It supports continuous-run and N-cycle single-step modes, stops on a core halt or a host abort, and keeps a saturating count of executed cycles.

## Interface
Parameters:
- `CNT_W`, default 32: width of the executed-cycle counter.
- `STEP_W`, default 8: width of the step-length input and the internal remaining-cycles counter.

Ports:
- `i_clk`, input, 1: the single clock. All state changes on the rising edge.
- `i_reset`, input, 1: reset, asynchronous and active-low.
- `i_start`, input, 1: start request, sampled in IDLE and DONE only.
- `i_mode`, input, 1: 0 = continuous, 1 = step. Sampled together with `i_start`.
- `i_step`, input, 1: step request, sampled in WAIT only.
- `i_step_count`, input, STEP_W: cycles per step, sampled with `i_step`. The value 0 is treated as 1.
- `i_halt`, input, 1: the core retired a halt. Sampled only while `o_valid`=1.
- `i_abort`, input, 1: host abort, honoured in RUN, WAIT and STEP.
- `o_valid`, output, 1: enable to the core (drives `top_mips_np.i_valid`).
- `o_busy`, output, 1: state is RUN, WAIT or STEP.
- `o_done`, output, 1: state is DONE.
- `o_state`, output, 3: state encoding.
- `o_cycle_cnt`, output, CNT_W: number of cycles with `o_valid`=1 since the last accepted start.

## Operation
- States and encodings: IDLE=0, RUN=1, WAIT=2, STEP=3, DONE=4.
- Unused state encodings 5–7 return to IDLE on the next edge.
- All outputs are pure decodes of registered state and counters:
  - `o_valid` = (RUN or STEP).
  - `o_busy` = (RUN, WAIT or STEP).
  - `o_done` = (DONE).
- IDLE:
  - `i_start`=1 with `i_mode`=0 goes to RUN.
  - `i_start`=1 with `i_mode`=1 goes to WAIT.
  - Either way, `o_cycle_cnt` clears to 0 on the same edge.
- RUN:
  - Each cycle, `o_cycle_cnt` increments.
  - `i_abort` or `i_halt` goes to DONE. The halt cycle itself is counted.
- WAIT:
  - `i_step`=1 goes to STEP and loads remaining = max(`i_step_count`, 1).
  - `i_abort` goes to DONE.
- STEP:
  - Each cycle, `o_cycle_cnt` increments and remaining decrements.
  - When remaining==1, go to WAIT.
  - `i_halt` or `i_abort` goes to DONE.
- DONE:
  - `o_cycle_cnt` holds its value.
  - `i_start` restarts exactly as from IDLE, including clearing the count.
- Priority when signals coincide: abort > halt > step-exhausted.
- `i_start` is ignored in RUN, WAIT and STEP. `i_step` is ignored outside WAIT. `i_abort` is ignored in IDLE and DONE.
- `o_cycle_cnt` saturates at all-ones and never wraps.
- The remaining counter is internal only and is don't-care outside STEP.

## Timing
- Reset (`i_reset`=0, asynchronous): state=IDLE, `o_valid`=0, `o_busy`=0, `o_done`=0, `o_state`=0, `o_cycle_cnt`=0, remaining=0.
- Reset mid-run or mid-step drops `o_valid` immediately, without waiting for a clock edge.
- Deassertion of reset takes effect at the next `i_clk` edge.
- Start latency: `i_start` sampled at edge k gives `o_valid`=1 from edge k in continuous mode. In step mode, WAIT is entered at edge k.
- Step latency: `i_step` sampled at edge k gives `o_valid` high for exactly N consecutive cycles, edges k..k+N-1. `o_valid` is 0 after edge k+N.
- Halt or abort sampled at edge k makes `o_valid` 0 and `o_done` 1 after edge k. There is no extra enabled cycle.
- A back-to-back step is allowed: `i_step`=1 on the first WAIT cycle after a step yields one idle cycle between bursts.

## Test plan
- Reset, then `i_start`=1, `i_mode`=0, then `i_halt` pulsed in the 10th enabled cycle:
  - `o_valid` high exactly 10 cycles.
  - `o_cycle_cnt`=10, `o_done`=1, `o_state`=4.
- Step mode with `i_step_count`=3, two `i_step` pulses:
  - Two 3-cycle `o_valid` bursts.
  - `o_cycle_cnt`=6, then back in WAIT (`o_state`=2).
- `i_step_count`=0:
  - One enabled cycle, `o_cycle_cnt`=1.
- `i_halt` and `i_abort` asserted together during STEP with remaining=5:
  - DONE next edge, remaining unused.
  - `i_start` afterwards clears `o_cycle_cnt` to 0.
- `CNT_W`=4, continuous run for 20 cycles then abort:
  - `o_cycle_cnt` stops at 15.
  - `i_start` and `i_step` are ignored while busy.
- `i_reset` dropped asynchronously mid-RUN:
  - `o_valid`, `o_busy` and `o_cycle_cnt` go to 0 before the next clock edge.
  - The controller is in IDLE after release.
